// File: rtl/orion_pkg.sv
// Shared types and helpers for the orion memory-game slice: FSM states,
// default RAM geometry and the colour-code to one-hot LED/button decode.
package orion_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int ADDR_W_DEF = 5;
    localparam int LEVEL_W    = 6;
    localparam int TMR_W      = 32;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_GAP        = 4'd1,
        ST_FETCH_SHOW = 4'd2,
        ST_SHOW_ON    = 4'd3,
        ST_SHOW_OFF   = 4'd4,
        ST_FETCH_IN   = 4'd5,
        ST_INPUT      = 4'd6,
        ST_LEVEL_UP   = 4'd7,
        ST_WIN        = 4'd8,
        ST_FAIL       = 4'd9
    } state_t;

    function automatic logic [3:0] led_onehot(input logic [1:0] code);
        case (code)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            2'd3:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter. A load of N-1 on the cycle a state is entered
// makes expired fire on the N-th cycle spent in that state.
module cycle_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] count_r;

    // Count down to zero, reloading whenever load is pulsed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= value;
        end else if (count_r != '0) begin
            count_r <= count_r - W'(1);
        end
    end

    // The loading cycle still holds the stale count, so it never reports expiry.
    assign expired = !load && (count_r <= W'(1));

endmodule

// File: rtl/seq_player.sv
// Memory-game player: replays a growing prefix of the sequence RAM on the LEDs
// and checks button presses. Optional inactivity timeout under PLAYER_TIMEOUT_EN.
module seq_player
    import orion_pkg::*;
#(
    parameter int SEQ_LEN        = 32,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int ON_CYCLES      = 25_000_000,
    parameter int OFF_CYCLES     = 12_500_000,
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seq_ready,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0]  rd_data,
    input  logic [3:0]         btn,
    output logic [3:0]         led,
    output logic [LEVEL_W-1:0] level,
    output logic               busy,
    output logic               player_turn,
    output logic               win,
    output logic               fail
);

    localparam logic [TMR_W-1:0]   GAP_LD     = TMR_W'(OFF_CYCLES - 1);
    localparam logic [TMR_W-1:0]   ON_LD      = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0]   FETCH_LD   = TMR_W'(2);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(SEQ_LEN);

    state_t             state_r;
    logic [ADDR_W-1:0]  idx_r;
    logic [1:0]         exp_r;
    logic               tmr_load_r;
    logic [TMR_W-1:0]   tmr_value_r;
    logic               tmr_expired_s;
    logic               more_s;
    logic               match_s;
    logic               unused_rd_s;

    // Only the low two data bits carry a colour code.
    assign unused_rd_s = ^rd_data[DATA_W-1:2];
    assign more_s      = (LEVEL_W'(idx_r) + LEVEL_W'(1)) < level;
    assign match_s     = (btn == led_onehot(exp_r));

    cycle_timer #(.W(TMR_W)) u_phase_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load_r),
        .value   (tmr_value_r),
        .expired (tmr_expired_s)
    );

`ifdef PLAYER_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TO_LD = TMR_W'(TIMEOUT_CYCLES - 1);
    logic to_load_r;
    logic to_expired_s;

    cycle_timer #(.W(TMR_W)) u_timeout_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (to_load_r),
        .value   (TO_LD),
        .expired (to_expired_s)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // Game FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            exp_r       <= 2'd0;
            tmr_load_r  <= 1'b0;
            tmr_value_r <= '0;
            rd_addr     <= '0;
            led         <= 4'b0000;
            level       <= '0;
            busy        <= 1'b0;
            player_turn <= 1'b0;
            win         <= 1'b0;
            fail        <= 1'b0;
`ifdef PLAYER_TIMEOUT_EN
            to_load_r   <= 1'b0;
`endif
        end else begin
            tmr_load_r <= 1'b0;
`ifdef PLAYER_TIMEOUT_EN
            to_load_r  <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (seq_ready) begin
                        win         <= 1'b0;
                        fail        <= 1'b0;
                        level       <= LEVEL_W'(1);
                        idx_r       <= '0;
                        busy        <= 1'b1;
                        tmr_load_r  <= 1'b1;
                        tmr_value_r <= GAP_LD;
                        state_r     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tmr_expired_s) begin
                        rd_addr     <= idx_r;
                        tmr_load_r  <= 1'b1;
                        tmr_value_r <= FETCH_LD;
                        state_r     <= ST_FETCH_SHOW;
                    end
                end
                ST_FETCH_SHOW: begin
                    if (tmr_expired_s) begin
                        exp_r       <= rd_data[1:0];
                        led         <= led_onehot(rd_data[1:0]);
                        tmr_load_r  <= 1'b1;
                        tmr_value_r <= ON_LD;
                        state_r     <= ST_SHOW_ON;
                    end
                end
                ST_SHOW_ON: begin
                    if (tmr_expired_s) begin
                        led         <= 4'b0000;
                        tmr_load_r  <= 1'b1;
                        tmr_value_r <= GAP_LD;
                        state_r     <= ST_SHOW_OFF;
                    end
                end
                ST_SHOW_OFF: begin
                    if (tmr_expired_s) begin
                        tmr_load_r  <= 1'b1;
                        tmr_value_r <= FETCH_LD;
                        if (more_s) begin
                            idx_r   <= idx_r + ADDR_W'(1);
                            rd_addr <= idx_r + ADDR_W'(1);
                            state_r <= ST_FETCH_SHOW;
                        end else begin
                            idx_r   <= '0;
                            rd_addr <= '0;
                            state_r <= ST_FETCH_IN;
                        end
                    end
                end
                ST_FETCH_IN: begin
                    if (tmr_expired_s) begin
                        exp_r       <= rd_data[1:0];
                        player_turn <= 1'b1;
                        state_r     <= ST_INPUT;
`ifdef PLAYER_TIMEOUT_EN
                        to_load_r   <= 1'b1;
`endif
                    end
                end
                ST_INPUT: begin
                    if (btn != 4'b0000) begin
                        player_turn <= 1'b0;
                        if (match_s) begin
                            if (more_s) begin
                                idx_r       <= idx_r + ADDR_W'(1);
                                rd_addr     <= idx_r + ADDR_W'(1);
                                tmr_load_r  <= 1'b1;
                                tmr_value_r <= FETCH_LD;
                                state_r     <= ST_FETCH_IN;
                            end else begin
                                state_r     <= ST_LEVEL_UP;
                            end
                        end else begin
                            fail    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= ST_FAIL;
                        end
                    end
`ifdef PLAYER_TIMEOUT_EN
                    else if (to_expired_s) begin
                        player_turn <= 1'b0;
                        fail        <= 1'b1;
                        busy        <= 1'b0;
                        state_r     <= ST_FAIL;
                    end
`endif
                end
                ST_LEVEL_UP: begin
                    if (level == LAST_LEVEL) begin
                        win     <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_WIN;
                    end else begin
                        level       <= level + LEVEL_W'(1);
                        idx_r       <= '0;
                        tmr_load_r  <= 1'b1;
                        tmr_value_r <= GAP_LD;
                        state_r     <= ST_GAP;
                    end
                end
                ST_WIN, ST_FAIL: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_player.sv
// Scoreboard bench for seq_player: expected output events are queued ahead of
// each stimulus step and a negedge monitor pops and compares them as they occur.
module tb_seq_player;

    localparam int ON_C  = 4;
    localparam int OFF_C = 2;
    localparam int TO_C  = 20;
    localparam int SEQ_N = 3;

    localparam int K_BUSY = 0, K_LEVEL = 1, K_WIN = 2, K_FAIL = 3,
                   K_TURN = 4, K_LEDON = 5, K_LEDOFF = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       seq_ready = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic [4:0] rd_addr;
    logic [3:0] rd_data;
    logic [3:0] led;
    logic [5:0] level;
    logic       busy, player_turn, win, fail;

    logic [3:0] mem [0:31];
    logic [3:0] ram_p1;

    typedef struct { int kind; int val; int dly; } ev_t;
    ev_t sb[$];

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  last_cyc = 0;
    bit  mon_en = 1'b0;

    seq_player #(
        .SEQ_LEN(SEQ_N), .ADDR_W(5), .DATA_W(4),
        .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .TIMEOUT_CYCLES(TO_C)
    ) dut (
        .clk(clk), .rst(rst), .seq_ready(seq_ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .btn(btn),
        .led(led), .level(level), .busy(busy),
        .player_turn(player_turn), .win(win), .fail(fail)
    );

    always #5 clk = ~clk;

    // Two-cycle read latency RAM model
    always @(posedge clk) begin
        ram_p1  <= mem[rd_addr];
        rd_data <= ram_p1;
    end

    function automatic string kname(input int k);
        case (k)
            K_BUSY:   return "busy";
            K_LEVEL:  return "level";
            K_WIN:    return "win";
            K_FAIL:   return "fail";
            K_TURN:   return "turn";
            K_LEDON:  return "led_on";
            K_LEDOFF: return "led_len";
            default:  return "other";
        endcase
    endfunction

    task automatic push(input int k, input int v, input int d);
        ev_t e;
        e.kind = k; e.val = v; e.dly = d;
        sb.push_back(e);
    endtask

    task automatic note(input int k, input int v);
        ev_t e;
        int  d;
        d = cyc - last_cyc;
        last_cyc = cyc;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s: got val=%0h at cycle %0d, required no event", kname(k), v, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.val != v || (e.dly >= 0 && e.dly != d)) begin
                bad++;
                $display("FAIL ev_%s: got %s val=%0h dly=%0d, required %s val=%0h dly=%0d",
                         kname(e.kind), kname(k), v, d, kname(e.kind), e.val, e.dly);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic pulse_ready();
        seq_ready = 1'b1;
        @(negedge clk);
        seq_ready = 1'b0;
    endtask

    task automatic press(input logic [3:0] v);
        btn = v;
        @(negedge clk);
        btn = 4'b0000;
    endtask

    task automatic wait_turn();
        int n = 0;
        while (!player_turn && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("turn_wait", int'(player_turn), 1);
    endtask

    task automatic wait_led();
        int n = 0;
        while (led == 4'b0000 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("led_wait", int'(led != 4'b0000), 1);
    endtask

    // Output monitor: turns output changes into events for the scoreboard
    initial begin
        logic       p_busy, p_win, p_fail, p_turn;
        logic [5:0] p_level;
        logic [3:0] p_led;
        int         on_cnt;
        p_busy = 1'b0; p_win = 1'b0; p_fail = 1'b0; p_turn = 1'b0;
        p_level = 6'd0; p_led = 4'b0000; on_cnt = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (busy != p_busy)         note(K_BUSY, int'(busy));
                if (level != p_level)       note(K_LEVEL, int'(level));
                if (win != p_win)           note(K_WIN, int'(win));
                if (fail != p_fail)         note(K_FAIL, int'(fail));
                if (player_turn != p_turn)  note(K_TURN, int'(player_turn));
                if (led != 4'b0000 && p_led == 4'b0000) begin
                    note(K_LEDON, int'({3'b000, rd_addr, 4'b0000, led}));
                    on_cnt = 1;
                end else if (led != 4'b0000) begin
                    on_cnt++;
                end else if (p_led != 4'b0000) begin
                    note(K_LEDOFF, on_cnt);
                end
            end
            p_busy = busy; p_win = win; p_fail = fail; p_turn = player_turn;
            p_level = level; p_led = led;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 4'h0;
        mem[0] = 4'hE;
        mem[1] = 4'h1;
        mem[2] = 4'h7;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_led", int'(led), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_win", int'(win), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_turn", int'(player_turn), 0);
        chk("rst_addr", int'(rd_addr), 0);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Reset while the first LED is lit
        push(K_BUSY, 1, -1); push(K_LEVEL, 1, 0); push(K_LEDON, 'h0004, 5);
        pulse_ready();
        wait_led();
        push(K_BUSY, 0, 1); push(K_LEVEL, 0, 0); push(K_LEDOFF, 1, 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_led", int'(led), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_level", int'(level), 0);
        press(4'b0100);
        repeat (5) @(negedge clk);

        // Round 1 correct, round 2 wrong on second element
        push(K_BUSY, 1, -1); push(K_LEVEL, 1, 0); push(K_LEDON, 'h0004, 5);
        push(K_LEDOFF, 4, 4); push(K_TURN, 1, 5);
        pulse_ready();
        wait_turn();
        push(K_TURN, 0, 1); push(K_LEVEL, 2, 1);
        push(K_LEDON, 'h0004, 5); push(K_LEDOFF, 4, 4);
        push(K_LEDON, 'h0102, 5); push(K_LEDOFF, 4, 4); push(K_TURN, 1, 5);
        press(4'b0100);
        wait_turn();
        push(K_TURN, 0, 1); push(K_TURN, 1, 3);
        press(4'b0100);
        wait_turn();
        push(K_BUSY, 0, 1); push(K_FAIL, 1, 0); push(K_TURN, 0, 0);
        press(4'b1000);
        repeat (3) @(negedge clk);
        chk("fail_flag", int'(fail), 1);
        chk("fail_busy", int'(busy), 0);
        chk("fail_level", int'(level), 2);

        // Full win with ignored mid-game seq_ready pulses
        push(K_BUSY, 1, -1); push(K_LEVEL, 1, 0); push(K_FAIL, 0, 0);
        push(K_LEDON, 'h0004, 5); push(K_LEDOFF, 4, 4); push(K_TURN, 1, 5);
        pulse_ready();
        wait_turn();
        push(K_TURN, 0, 1); push(K_LEVEL, 2, 1);
        push(K_LEDON, 'h0004, 5); push(K_LEDOFF, 4, 4);
        push(K_LEDON, 'h0102, 5); push(K_LEDOFF, 4, 4); push(K_TURN, 1, 5);
        press(4'b0100);
        pulse_ready();
        wait_turn();
        push(K_TURN, 0, 1); push(K_TURN, 1, 3);
        press(4'b0100);
        wait_turn();
        push(K_TURN, 0, 1); push(K_LEVEL, 3, 1);
        push(K_LEDON, 'h0004, 5); push(K_LEDOFF, 4, 4);
        push(K_LEDON, 'h0102, 5); push(K_LEDOFF, 4, 4);
        push(K_LEDON, 'h0208, 5); push(K_LEDOFF, 4, 4); push(K_TURN, 1, 5);
        press(4'b0010);
        wait_turn();
        push(K_TURN, 0, 2); push(K_TURN, 1, 3);
        pulse_ready();
        press(4'b0100);
        wait_turn();
        push(K_TURN, 0, 1); push(K_TURN, 1, 3);
        press(4'b0010);
        wait_turn();
        push(K_TURN, 0, 1); push(K_BUSY, 0, 1); push(K_WIN, 1, 0);
        press(4'b1000);
        repeat (3) @(negedge clk);
        chk("win_flag", int'(win), 1);
        chk("win_busy", int'(busy), 0);
        chk("win_level", int'(level), 3);
        chk("win_nofail", int'(fail), 0);

        // Player never presses
        push(K_BUSY, 1, -1); push(K_LEVEL, 1, 0); push(K_WIN, 0, 0);
        push(K_LEDON, 'h0004, 5); push(K_LEDOFF, 4, 4); push(K_TURN, 1, 5);
        pulse_ready();
        wait_turn();
`ifdef PLAYER_TIMEOUT_EN
        push(K_BUSY, 0, TO_C); push(K_FAIL, 1, 0); push(K_TURN, 0, 0);
        repeat (30) @(negedge clk);
        chk("to_fail", int'(fail), 1);
        chk("to_busy", int'(busy), 0);
`else
        repeat (1000) @(negedge clk);
        chk("noto_fail", int'(fail), 0);
        chk("noto_busy", int'(busy), 1);
        chk("noto_turn", int'(player_turn), 1);
`endif
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
